// File: rtl/wb_regfile_stage_pkg.sv
// wb_regfile_stage_pkg: shared write-back encodings and width defaults.
package wb_regfile_stage_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_LOAD = 2'b01,
        MTR_LINK = 2'b10,
        MTR_RSVD = 2'b11
    } mtr_e;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_source_mux.sv
// wb_source_mux: MemtoReg-driven write-back value select; reserved code falls back to the ALU result.
module wb_source_mux
    import wb_regfile_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] load,
    input  logic [DATA_W-1:0] link,
    output logic [DATA_W-1:0] data
);
    assign data = (sel == MTR_LOAD) ? load : (sel == MTR_LINK) ? link : alu;
endmodule

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: write-back select, register file with two async read ports, retired-write counter.
// Define WB_BYPASS_EN to forward a same-cycle write straight to the read ports.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] inLoadWordData,
    input  logic [DATA_W-1:0] inAluResult,
    input  logic [DATA_W-1:0] inPcLink,
    input  logic [ADDR_W-1:0] inWriteReg,
    input  logic              inRegWrite,
    input  logic [1:0]        inMemtoReg,
    input  logic [ADDR_W-1:0] inReadRegA,
    input  logic [ADDR_W-1:0] inReadRegB,
    output logic [DATA_W-1:0] outReadDataA,
    output logic [DATA_W-1:0] outReadDataB,
    output logic [DATA_W-1:0] outWbData,
    output logic [ADDR_W-1:0] outWbReg,
    output logic              outWbWrite,
    output logic [CNT_W-1:0]  outCommitCount
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] stored_a, stored_b;

    wb_source_mux #(.DATA_W(DATA_W)) u_mux (
        .sel  (inMemtoReg),
        .alu  (inAluResult),
        .load (inLoadWordData),
        .link (inPcLink),
        .data (outWbData)
    );

    assign outWbReg       = inWriteReg;
    assign outWbWrite     = inRegWrite && (inWriteReg != ZERO);
    assign outCommitCount = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            count <= '0;
        end else if (outWbWrite) begin
            regs[inWriteReg] <= outWbData;
            count            <= count + CNT_W'(1);
        end
    end

    assign stored_a = (inReadRegA == ZERO) ? '0 : regs[inReadRegA];
    assign stored_b = (inReadRegB == ZERO) ? '0 : regs[inReadRegB];

`ifdef WB_BYPASS_EN
    // Bypass is held off during reset so the ports show the cleared file.
    assign outReadDataA = (rst_n && outWbWrite && inReadRegA == inWriteReg) ? outWbData : stored_a;
    assign outReadDataB = (rst_n && outWbWrite && inReadRegB == inWriteReg) ? outWbData : stored_b;
`else
    assign outReadDataA = stored_a;
    assign outReadDataB = stored_b;
`endif
endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb_wb_regfile_stage: directed and random checks of wb_regfile_stage against an array-based model.
// Expectations follow WB_BYPASS_EN when the same macro is defined for the bench.
module tb_wb_regfile_stage;
    logic        clk = 0;
    logic        rst_n;
    logic [31:0] ld, alu, lnk;
    logic [4:0]  wr, ra, rb;
    logic        rw;
    logic [1:0]  mtr;
    logic [31:0] rd_a, rd_b, wb_data, rd_a_s, rd_b_s, wb_data_s;
    logic [4:0]  wb_reg, wb_reg_s;
    logic        wb_write, wb_write_s;
    logic [31:0] cnt_out;
    logic [1:0]  cnt_s_out;

    logic [31:0] mdl [32];
    logic [31:0] cnt;
    int          total = 0;
    int          bad = 0;
    bit          chk_wb = 1;

    always #5 clk = ~clk;

    wb_regfile_stage dut (
        .clk(clk), .rst_n(rst_n), .inLoadWordData(ld), .inAluResult(alu), .inPcLink(lnk),
        .inWriteReg(wr), .inRegWrite(rw), .inMemtoReg(mtr), .inReadRegA(ra), .inReadRegB(rb),
        .outReadDataA(rd_a), .outReadDataB(rd_b), .outWbData(wb_data), .outWbReg(wb_reg),
        .outWbWrite(wb_write), .outCommitCount(cnt_out)
    );

    // Narrow-counter copy exercises the modulo wrap within a short run.
    wb_regfile_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .inLoadWordData(ld), .inAluResult(alu), .inPcLink(lnk),
        .inWriteReg(wr), .inRegWrite(rw), .inMemtoReg(mtr), .inReadRegA(ra), .inReadRegB(rb),
        .outReadDataA(rd_a_s), .outReadDataB(rd_b_s), .outWbData(wb_data_s), .outWbReg(wb_reg_s),
        .outWbWrite(wb_write_s), .outCommitCount(cnt_s_out)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        case (mtr)
            2'd1:    return ld;
            2'd2:    return lnk;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (rst_n && rw && wr == a) return exp_wb();
`endif
        return mdl[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        cnt = 32'h0;
    endtask

    task automatic cycle();
        logic [31:0] wv;
        logic        we;
        #1;
        wv = exp_wb();
        we = rw && (wr != 0);
        if (chk_wb) check("wb_data", wb_data, wv);
        check("wb_write", {31'b0, wb_write}, {31'b0, we});
        check("wb_reg", {27'b0, wb_reg}, {27'b0, wr});
        check("rd_a_pre", rd_a, exp_rd(ra));
        check("rd_b_pre", rd_b, exp_rd(rb));
        @(posedge clk);
        if (rst_n && we) begin
            mdl[wr] = wv;
            cnt++;
        end
        #1;
        check("rd_a_post", rd_a, exp_rd(ra));
        check("rd_b_post", rd_b, exp_rd(rb));
        check("count", cnt_out, cnt);
        check("count_narrow", {30'b0, cnt_s_out}, {30'b0, cnt[1:0]});
    endtask

    initial begin
        clear_model();
        rst_n = 0; rw = 1; wr = 5; alu = 32'h1234; ld = 0; lnk = 0; mtr = 0; ra = 5; rb = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_reg5", rd_a, 32'h0);
        check("rst_count", cnt_out, 32'h0);
        rst_n = 1;
        cycle();
        check("rel_reg5", rd_a, 32'h1234);
        check("rel_count", cnt_out, 32'h1);

        wr = 8; rw = 1; alu = 32'hA; ld = 32'hB; lnk = 32'hC; ra = 8; rb = 8;
        for (int s = 0; s < 4; s++) begin
            mtr = 2'(s);
            cycle();
            check("src_sel", rd_a, (s == 1) ? 32'hB : (s == 2) ? 32'hC : 32'hA);
        end
        check("src_count", cnt_out, 32'd5);

        wr = 0; alu = 32'hFFFF_FFFF; mtr = 0; ra = 0; rb = 8;
        cycle();
        check("zero_rd", rd_a, 32'h0);
        check("zero_count", cnt_out, 32'd5);

        rw = 0; wr = 9; mtr = 2'bxx; ra = 9; chk_wb = 0;
        cycle();
        chk_wb = 1;
        check("x_sel_count", cnt_out, 32'd5);

        rw = 1; wr = 3; alu = 32'h11; mtr = 0; ra = 3; rb = 3;
        cycle();
        alu = 32'h22;
        #1;
`ifdef WB_BYPASS_EN
        check("byp_a_pre", rd_a, 32'h22);
        check("byp_b_pre", rd_b, 32'h22);
`else
        check("byp_a_pre", rd_a, 32'h11);
        check("byp_b_pre", rd_b, 32'h11);
`endif
        cycle();
        check("byp_a_post", rd_a, 32'h22);
        check("byp_b_post", rd_b, 32'h22);

        wr = 10; mtr = 1;
        for (int k = 0; k < 3; k++) begin
            ld = 32'h100 + 32'(k);
            cycle();
            check("wrap_narrow", {30'b0, cnt_s_out}, (k == 0) ? 32'd0 : (k == 1) ? 32'd1 : 32'd2);
        end

        rw = 1; wr = 7; alu = 32'h77; mtr = 0; ra = 7; rb = 3;
        #2;
        rst_n = 0;
        #1;
        clear_model();
        check("arst_rd_a", rd_a, 32'h0);
        check("arst_rd_b", rd_b, 32'h0);
        check("arst_count", cnt_out, 32'h0);
        @(posedge clk);
        #1;
        check("arst_edge_rd", rd_a, 32'h0);
        check("arst_edge_count", cnt_out, 32'h0);
        rst_n = 1;
        cycle();
        check("arst_first", rd_a, 32'h77);

        for (int n = 0; n < 300; n++) begin
            rw  = ($urandom_range(0, 3) != 0);
            wr  = 5'($urandom);
            mtr = 2'($urandom);
            alu = $urandom;
            ld  = $urandom;
            lnk = $urandom;
            ra  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Write-back end of the pipeline; consumes the fields held by the MEM/WB pipeline register.
- Selects the write-back value using the MemtoReg code and commits it into a 32x32 register file.
- Serves two asynchronous read ports to the ID stage.
- Exports the current write-back triple to the forwarding unit and keeps a retired-write counter.

Parameters:
- DATA_W, 32, data and register width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- CNT_W, 32, width of the commit counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inLoadWordData  in  DATA_W  load data from the MEM/WB register.
- inAluResult  in  DATA_W  ALU result from the MEM/WB register.
- inPcLink  in  DATA_W  link address (PC+8) from the MEM/WB register.
- inWriteReg  in  ADDR_W  destination register (Rt/Rd mux result).
- inRegWrite  in  1  write enable from the MEM/WB register.
- inMemtoReg  in  2  write-back source select.
- inReadRegA  in  ADDR_W  ID read address A.
- inReadRegB  in  ADDR_W  ID read address B.
- outReadDataA  out  DATA_W  read data A.
- outReadDataB  out  DATA_W  read data B.
- outWbData  out  DATA_W  selected write-back value (to forwarding).
- outWbReg  out  ADDR_W  equals inWriteReg.
- outWbWrite  out  1  inRegWrite AND (inWriteReg != 0).
- outCommitCount  out  CNT_W  number of committed writes.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: all 32 registers = 0 and outCommitCount = 0, immediately and independent of clk.
  - Read outputs then reflect the zeroed file.
- Source select (combinational) on inMemtoReg:
  - 00 = inAluResult.
  - 01 = inLoadWordData.
  - 10 = inPcLink.
  - 11 = reserved, selects inAluResult.
- Commit: at the rising clk edge with rst_n=1, if outWbWrite=1 then reg[inWriteReg] <= outWbData and outCommitCount increments by 1.
  - Latency: one edge. Data is visible on the read ports after that edge.
- Register 0: never written; reads of index 0 always return 0. A write to 0 is dropped and not counted.
- Counter: wraps modulo 2**CNT_W with no saturation. 0xFFFFFFFF plus one commit gives 0.
- Reads: combinational, no clock. Ports A and B are fully independent and may address the same register.
- Reset mid-operation:
  - Assertion in the same cycle as a pending write: the write is discarded.
  - Deassertion: the first commit can occur at the next rising edge after rst_n rises.
- Unknowns: X on inMemtoReg while outWbWrite=0 must not disturb any state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when outWbWrite=1 and inReadRegX == inWriteReg (X = A or B, index != 0), outReadDataX = outWbData in the same cycle (write-through). This removes the WB-to-ID hazard.
- Undefined: read ports always return stored contents. The value from a same-cycle write appears only after the edge, and the hazard unit must stall one cycle.

Decomposition:
- Shared package:
  - MemtoReg encodings MTR_ALU=2'b00, MTR_LOAD=2'b01, MTR_LINK=2'b10.
  - REG_ZERO=5'd0.
  - DATA_W/ADDR_W defaults.
- One natural sub-module, wb_source_mux: combinational 4:1 select producing outWbData. It is reused by the forwarding unit.
- The register array, bypass and counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with inRegWrite=1, inWriteReg=5, inAluResult=0x1234 over two edges.
  - Required: reg5 reads 0 and outCommitCount=0.
  - After release, one edge writes 0x1234 and count=1.
- Source select: inWriteReg=8, inRegWrite=1, with inAluResult=0xA, inLoadWordData=0xB, inPcLink=0xC. Apply MemtoReg 00/01/10/11 on successive edges.
  - Required: reg8 = 0xA, 0xB, 0xC, 0xA after each respective edge; count +4.
- Zero register: write 0xFFFFFFFF to index 0.
  - Required: read A=0 and outWbWrite=0; count unchanged.
- Bypass: reg3=0x11; in one cycle write 0x22 to reg3 while inReadRegA=3 and inReadRegB=3.
  - With WB_BYPASS_EN: both ports show 0x22 before the edge.
  - Without it: both show 0x11 before the edge and 0x22 after.
- Wrap: force the counter to 0xFFFFFFFE, then perform 3 valid commits.
  - Required: count reads 0xFFFFFFFF, 0x00000000, 0x00000001.
- Async reset mid-stream: assert rst_n low between edges while a write is pending.
  - Required: all reads 0 immediately, no commit at the next edge, count 0.
